pingpong_buffer_nch: RTL

- Parametrised successor to the per-component ping-pong memories that sit between the modulation mapper and the FFT stage.
- One instance buffers CHANNELS parallel sample lanes (e.g. I and Q) in two banks. It replaces the current arrangement of one memory instance per component.
- Frames have variable length, closed by wr_last. The buffer reports each frame's length, produces a last-word strobe on the read side, uses valid/ready handshakes on both sides, and flags overflow and truncation.
- Single clock domain; rate adaptation is done by the surrounding clock enables.

---
 rtl/pingpong_buffer_nch.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pingpong_buffer_nch.sv
// rtl/pingpong_buffer_nch.sv - multi-lane ping-pong frame buffer with valid/ready on both sides
// Purpose: two banks of DEPTH words, each word holding CHANNELS lanes of DATA_WIDTH bits.
//   One bank fills while the other drains; frames close on wr_last or at DEPTH words.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   wr_valid, wr_data, wr_last, wr_ready : write stream
//   rd_valid, rd_data, rd_last, rd_ready : read stream, one word per cycle while rd_ready=1
//   rd_frame_len                        : length of the frame currently being read
//   overflow, truncated                 : sticky error flags
//   frames_done                         : wrapping count of fully read frames
module pingpong_buffer_nch #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 1200,
  parameter int ADDR_W     = 11
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
  input  logic                           wr_last,
  output logic                           wr_ready,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
  output logic                           rd_last,
  output logic [ADDR_W-1:0]              rd_frame_len,
  output logic                           overflow,
  output logic                           truncated,
  output logic [15:0]                    frames_done
);

  localparam int W  = CHANNELS * DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ONE      = 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_st_t;

  bank_st_t          r_bank_st     [2];
  bank_st_t          w_bank_st_nxt [2];
  logic [ADDR_W-1:0] r_len         [2];
  logic [W-1:0]      r_mem0 [0:DEPTH-1];
  logic [W-1:0]      r_mem1 [0:DEPTH-1];

  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_rd_bank;
  logic              r_rd_active;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_out_bank;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [W-1:0]      r_rd_data;
  logic [ADDR_W-1:0] r_rd_frame_len;
  logic              r_overflow;
  logic              r_truncated;
  logic [15:0]       r_frames_done;

  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_wr_close;
  logic              w_rd_fire;
  logic              w_rd_free;
  logic              w_issue_ok;
  logic              w_start;
  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic [ADDR_W-1:0] w_rd_len;
  logic [W-1:0]      w_rd_word;

  // wr_ready depends only on registered bank state, never on rd_ready.
  assign w_wr_ready = (r_bank_st[r_wr_bank] == ST_EMPTY) || (r_bank_st[r_wr_bank] == ST_FILLING);
  assign w_wr_fire  = wr_valid && w_wr_ready;
  assign w_wr_close = w_wr_fire && (wr_last || (r_wr_ptr == LAST_PTR));

  assign w_rd_fire  = r_rd_valid && rd_ready;
  assign w_rd_free  = w_rd_fire && r_rd_last;

  // The RAM output register doubles as the output stage: a new read is issued only
  // when the word it holds is empty or leaving this cycle, so a stall simply
  // suppresses the read and the held word stays put.
  assign w_issue_ok   = !r_rd_valid || rd_ready;
  assign w_start      = !r_rd_active && (r_bank_st[r_rd_bank] == ST_FULL) && w_issue_ok;
  assign w_issue      = w_start || (r_rd_active && w_issue_ok);
  assign w_rd_ptr     = w_start ? '0 : r_rd_ptr;
  assign w_rd_len     = w_start ? r_len[r_rd_bank] : r_rd_frame_len;
  assign w_issue_last = (w_rd_ptr == (w_rd_len - ONE));
  assign w_rd_word    = r_rd_bank ? r_mem1[w_rd_ptr[PW-1:0]] : r_mem0[w_rd_ptr[PW-1:0]];

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_st_nxt[b] = r_bank_st[b];
      case (r_bank_st[b])
        ST_EMPTY:
          if (w_wr_fire && (r_wr_bank == 1'(b)))
            w_bank_st_nxt[b] = w_wr_close ? ST_FULL : ST_FILLING;
        ST_FILLING:
          if (w_wr_close && (r_wr_bank == 1'(b)))
            w_bank_st_nxt[b] = ST_FULL;
        ST_FULL:
          if (w_start && (r_rd_bank == 1'(b)))
            w_bank_st_nxt[b] = ST_DRAINING;
        ST_DRAINING:
          if (w_rd_free && (r_out_bank == 1'(b)))
            w_bank_st_nxt[b] = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank_st[0] <= ST_EMPTY;
      r_bank_st[1] <= ST_EMPTY;
    end else begin
      r_bank_st[0] <= w_bank_st_nxt[0];
      r_bank_st[1] <= w_bank_st_nxt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_wr_fire && !r_wr_bank) r_mem0[r_wr_ptr[PW-1:0]] <= wr_data;
    if (!reset && w_wr_fire &&  r_wr_bank) r_mem1[r_wr_ptr[PW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_bank   <= 1'b0;
      r_wr_ptr    <= '0;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
      r_overflow  <= 1'b0;
      r_truncated <= 1'b0;
    end else begin
      if (wr_valid && !w_wr_ready) r_overflow <= 1'b1;
      if (w_wr_fire) begin
        if (w_wr_close) begin
          r_len[r_wr_bank] <= r_wr_ptr + ONE;
          r_wr_ptr         <= '0;
          r_wr_bank        <= ~r_wr_bank;
          if (!wr_last) r_truncated <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_bank      <= 1'b0;
      r_rd_active    <= 1'b0;
      r_rd_ptr       <= '0;
      r_out_bank     <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_last      <= 1'b0;
      r_rd_data      <= '0;
      r_rd_frame_len <= '0;
      r_frames_done  <= '0;
    end else begin
      if (w_issue) begin
        r_rd_data  <= w_rd_word;
        r_rd_valid <= 1'b1;
        r_rd_last  <= w_issue_last;
        r_out_bank <= r_rd_bank;
        if (w_start) r_rd_frame_len <= r_len[r_rd_bank];
        if (w_issue_last) begin
          r_rd_active <= 1'b0;
          r_rd_ptr    <= '0;
          r_rd_bank   <= ~r_rd_bank;
        end else begin
          r_rd_active <= 1'b1;
          r_rd_ptr    <= w_rd_ptr + ONE;
        end
      end else if (w_rd_fire) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
      if (w_rd_free) r_frames_done <= r_frames_done + 16'd1;
    end
  end

  assign wr_ready     = w_wr_ready;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign rd_last      = r_rd_last;
  assign rd_frame_len = r_rd_frame_len;
  assign overflow     = r_overflow;
  assign truncated    = r_truncated;
  assign frames_done  = r_frames_done;

endmodule
